ttl_74169_sync: RTL
===================

# ttl_74169_sync

Synthesizable model of the LS169 4-bit synchronous up/down binary counter with parallel load, widened by parameter. It is the down-counting complement to the family's up-only loadable counters. Video timing and sprite-line logic use it where a down count or an underflow flag is needed, for example to count a loaded value down to zero and then raise a terminal flag. All state advances on the system clock and is qualified by a rising edge of the clock-enable strobe `Cen`, so the counter behaves like a discrete TTL part clocked by `Cen`.

## Interface
- `WIDTH`, default 4: counter width in bits.

- `Clk`  in  1  system clock; every register updates on its rising edge.
- `Rst`  in  1  synchronous reset, active-high.
- `Load_bar`  in  1  parallel load, active-low (pin 9).
- `U_D`  in  1  count direction: 1 = up, 0 = down (pin 1).
- `ENP_bar`  in  1  count enable P, active-low (pin 7).
- `ENT_bar`  in  1  count enable T, active-low (pin 10). Also gates `RCO_bar`.
- `D`  in  WIDTH  parallel data. For WIDTH 4: D pin 6, C pin 5, B pin 4, A pin 3.
- `Cen`  in  1  emulated TTL clock. An action fires only on its 0→1 transition.
- `RCO_bar`  out  1  ripple carry/borrow out, active-low (pin 15).
- `Q`  out  WIDTH  count value. For WIDTH 4: QD pin 11, QC pin 12, QB pin 13, QA pin 14.

## Operation
- Edge qualifier:
  - `last_cen` is registered every `Clk`.
  - `tick = Cen & !last_cen`.
  - All actions below require `tick`.
- Priority on `tick`, highest first:
  1. `Load_bar`=0: `Q` ← `D`. This ignores `ENP_bar`, `ENT_bar` and `U_D`.
  2. `Load_bar`=1, `ENP_bar`=0, `ENT_bar`=0, `U_D`=1: `Q` ← `Q`+1, modulo 2^WIDTH.
  3. `Load_bar`=1, `ENP_bar`=0, `ENT_bar`=0, `U_D`=0: `Q` ← `Q`−1, modulo 2^WIDTH.
  4. Any other combination: `Q` holds.
- Wrap-around:
  - Up from all-ones gives 0.
  - Down from 0 gives all-ones.
  - No saturation.
- No clear input. Only `Rst` forces `Q` to 0.
- `RCO_bar` is combinational from the registered `Q` and the current `ENT_bar` and `U_D`:
  - 0 when `ENT_bar`=0 and `U_D`=1 and `Q`=all-ones.
  - 0 when `ENT_bar`=0 and `U_D`=0 and `Q`=0.
  - 1 otherwise.
- `ENP_bar` does not affect `RCO_bar`.
- Cascading: stage n+1 `ENT_bar` is driven by stage n `RCO_bar`. All stages share `Cen` and `U_D`.

## Timing
- Reset (`Rst`=1 at a `Clk` edge):
  - `Q` = 0.
  - `last_cen` = 1, so a `Cen` already high when reset releases does not fire.
  - `RCO_bar` then follows the combinational rule from `Q`=0. It is 0 if `ENT_bar`=0 and `U_D`=0.
- Reset dominates everything, including a `tick` in the same cycle.
- A reset asserted mid-count discards the count.
- Latency: `Q` changes on the `Clk` edge where `tick` is sampled true, and is visible the following cycle. `RCO_bar` follows in the same cycle as the new `Q`.
- A `Cen` held high for N cycles produces exactly one action.
- `Cen` high for a single cycle, low for a single cycle, repeating, produces an action every 2 cycles. This is the maximum rate.
- Inputs `Load_bar`, `U_D`, `ENP_bar`, `ENT_bar` and `D` are sampled only on the `tick` cycle. Changes between ticks have no effect on `Q`.
- Changing `U_D` between ticks changes `RCO_bar` immediately, with no register delay.

## Test plan
- Reset, then up count:
  - Stimulus: assert `Rst` with `Cen` held high, release, keep `Cen` high 5 cycles.
  - Required: `Q`=0 throughout, no count.
  - Stimulus: pulse `Cen` 3 times with `U_D`=1 and both enables low.
  - Required: `Q`=3.
- Down wrap, WIDTH=4:
  - Stimulus: load `D`=1, then give 2 down ticks.
  - Required: `Q`=0, then `Q`=15.
  - Required: `RCO_bar`=0 only while `Q`=0 and `ENT_bar`=0.
- Load priority:
  - Stimulus: `Q`=7; `Load_bar`=0, `ENP_bar`=1, `D`=0xA; one tick.
  - Required: `Q`=0xA.
  - Stimulus: same inputs with `Load_bar`=1.
  - Required: `Q` holds at 0xA.
- Enable gating:
  - `ENP_bar`=1, `ENT_bar`=0, `Q`=15, `U_D`=1, 4 ticks: `Q` holds at 15 and `RCO_bar`=0.
  - `ENT_bar`=1 with the same inputs: `RCO_bar`=1.
- Two-stage cascade, WIDTH=4:
  - Stimulus: load 0x0F into the stage pair, then one up tick.
  - Required: pair reads 0x10.
  - Stimulus: load 0x10, then one down tick.
  - Required: pair reads 0x0F.
- Mid-operation reset:
  - Stimulus: `Rst` asserted in the same cycle as a `tick` with `Load_bar`=0 and `D`=9.
  - Required: `Q`=0.

Source files
------------

// File: rtl/ttl_74169_sync.sv
// LS169-style synchronous up/down binary counter with parallel load, widened by WIDTH.
// The emulated TTL clock Cen acts only on its rising edge, detected against the system clock Clk.
module ttl_74169_sync #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Load_bar,
    input  logic             U_D,
    input  logic             ENP_bar,
    input  logic             ENT_bar,
    input  logic [WIDTH-1:0] D,
    input  logic             Cen,
    output logic             RCO_bar,
    output logic [WIDTH-1:0] Q
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             last_cen;
    logic             tick;
    logic             count_en;
    logic [WIDTH-1:0] q_next;

    assign tick     = Cen & ~last_cen;
    assign count_en = ~ENP_bar & ~ENT_bar;

    // last_cen resets high so a Cen already high at reset release does not fire.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            last_cen <= 1'b1;
        end else begin
            last_cen <= Cen;
        end
    end

    always_comb begin
        q_next = Q;
        if (tick) begin
            if (!Load_bar) begin
                q_next = D;
            end else if (count_en) begin
                q_next = U_D ? (Q + ONE) : (Q - ONE);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Q <= '0;
        end else begin
            Q <= q_next;
        end
    end

    // Terminal count: all-ones going up, zero going down, gated only by ENT_bar.
    always_comb begin
        RCO_bar = 1'b1;
        if (!ENT_bar) begin
            if (U_D && (Q == ALL_ONES)) begin
                RCO_bar = 1'b0;
            end else if (!U_D && (Q == '0)) begin
                RCO_bar = 1'b0;
            end
        end
    end

endmodule
